seg7_scan_mux: RTL

- Consumes the 16-bit BCD mm:ss value from the stopwatch timer and drives a 4-digit common-anode 7-segment display by time-multiplexing one digit at a time.
- Sits directly downstream of the timer, in the fast system clock domain.
- Provides tear-free capture of the slowly changing, ripple-generated BCD bus, BCD-to-segment decode, leading-zero blanking, per-digit decimal point, and an anti-ghosting blank gap.

---
 rtl/seg7_scan_mux.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed 7-segment driver for the stopwatch mm:ss BCD bus.
// Shadow capture is frame-aligned, outputs are registered with polarity applied.
module seg7_scan_mux #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit DIG_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] bcd_num,
  input  logic [3:0]  dp_mask,
  input  logic        lz_blank,
  output logic [3:0]  dig,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK   = DW'(BLANK_CYC);
  localparam logic [3:0] DIG_INV = DIG_ACT_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_INV = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_INV  = SEG_ACT_LOW;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   samp_a_q, samp_b_q, shadow_q, shadow_d;
  logic [3:0]    dig_q, dig_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q;

  logic          div_wrap, frame_end;
  logic [3:0]    nib;
  logic          blanked, act;
  logic [6:0]    seg_a;
  logic          z3, z2, z1;

  assign div_wrap  = (div_q == DIV_MAX);
  assign frame_end = div_wrap && (idx_q == 2'd3);

  assign z3 = (shadow_q[15:12] == 4'd0);
  assign z2 = (shadow_q[11:8]  == 4'd0);
  assign z1 = (shadow_q[7:4]   == 4'd0);

  always_comb begin
    div_d    = div_wrap ? '0 : div_q + DW'(1);
    idx_d    = div_wrap ? idx_q + 2'd1 : idx_q;
    shadow_d = shadow_q;
    // Only accept a value that held steady across both sample stages.
    if (frame_end && (samp_a_q == samp_b_q))
      shadow_d = samp_b_q;
  end

  always_comb begin
    nib = shadow_q[{idx_q, 2'b00} +: 4];
    blanked = 1'b0;
    if (lz_blank) begin
      unique case (idx_q)
        2'd3:    blanked = z3;
        2'd2:    blanked = z3 && z2;
        2'd1:    blanked = z3 && z2 && z1;
        default: blanked = 1'b0;
      endcase
    end
  end

  always_comb begin
    unique case (nib)
      4'd0:    seg_a = 7'h3F;
      4'd1:    seg_a = 7'h06;
      4'd2:    seg_a = 7'h5B;
      4'd3:    seg_a = 7'h4F;
      4'd4:    seg_a = 7'h66;
      4'd5:    seg_a = 7'h6D;
      4'd6:    seg_a = 7'h7D;
      4'd7:    seg_a = 7'h07;
      4'd8:    seg_a = 7'h7F;
      4'd9:    seg_a = 7'h6F;
      default: seg_a = 7'h40;
    endcase
  end

  always_comb begin
    act   = en && (div_q >= BLANK) && !blanked;
    dig_d = DIG_INV;
    seg_d = SEG_INV;
    dp_d  = DP_INV;
    if (act) begin
      dig_d = (4'b0001 << idx_q) ^ DIG_INV;
      seg_d = seg_a ^ SEG_INV;
      dp_d  = dp_mask[idx_q] ^ DP_INV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      idx_q    <= 2'd0;
      samp_a_q <= 16'h0000;
      samp_b_q <= 16'h0000;
      shadow_q <= 16'h0000;
      dig_q    <= DIG_INV;
      seg_q    <= SEG_INV;
      dp_q     <= DP_INV;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      samp_a_q <= bcd_num;
      samp_b_q <= samp_a_q;
      shadow_q <= shadow_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= frame_end;
    end
  end

  assign dig        = dig_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
